// File: rtl/wall_game_pkg.sv
// Shared types and helpers for the hole-in-the-wall round controller.
package wall_game_pkg;

  localparam int DEPTH_W = 8;

  typedef enum logic [2:0] {
    GS_LOST      = 3'd0,
    GS_PLAYING   = 3'd1,
    GS_WON       = 3'd2,
    GS_IDLE      = 3'd3,
    GS_COUNTDOWN = 3'd4
  } game_state_t;

  // Frames per depth step for a given round, floored at min_frames; signed math avoids wrap.
  function automatic int tick_period(input int round, input int max_frames,
                                     input int min_frames, input int step);
    int p;
    p = max_frames - round * step;
    if (p < min_frames) p = min_frames;
    return p;
  endfunction

  function automatic int depth_win_lo(input int goal, input int delta);
    return (goal > delta) ? goal - delta : 0;
  endfunction

  function automatic int depth_win_hi(input int goal, input int delta);
    return goal + delta;
  endfunction

endpackage

// File: rtl/wall_round_controller_if.sv
// Pixel side-band stream entering the round controller and its 1-cycle registered copy.
interface wall_round_controller_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  logic        is_wall_in;
  logic        is_person_in;
  logic [7:0]  player_depth_in;

  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;
  logic        is_wall_out;
  logic        is_person_out;
  logic [7:0]  player_depth_out;
  logic        is_collision_out;

  modport master (
    output hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in, player_depth_in,
    input  hcount_out, vcount_out, data_valid_out, is_wall_out, is_person_out,
           player_depth_out, is_collision_out
  );

  modport slave (
    input  hcount_in, vcount_in, data_valid_in, is_wall_in, is_person_in, player_depth_in,
    output hcount_out, vcount_out, data_valid_out, is_wall_out, is_person_out,
           player_depth_out, is_collision_out
  );
endinterface

// File: rtl/wall_round_controller_judge.sv
// Collision judge: counts colliding pixels per frame and flags at most one life loss per round.
module collision_judge
  import wall_game_pkg::*;
#(
  parameter int COLLISION_THRESHOLD = 64
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  input  logic count_en,
  input  logic pixel_hit,
  input  logic frame_end,
  output logic lose_life,
  output logic round_hit
);

  localparam int HIT_W = $clog2(COLLISION_THRESHOLD + 1);
  localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(COLLISION_THRESHOLD);

  logic [HIT_W-1:0] hit_cnt;
  logic [HIT_W-1:0] hit_next;

  // The frame-closing pixel itself is included in the verdict.
  always_comb begin
    hit_next = hit_cnt;
    if (count_en && pixel_hit && hit_cnt != HIT_MAX) hit_next = hit_cnt + HIT_W'(1);
  end

  assign lose_life = frame_end && (hit_next == HIT_MAX) && !round_hit;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_cnt   <= '0;
      round_hit <= 1'b0;
    end else begin
      if (clr || frame_end) hit_cnt <= '0;
      else                  hit_cnt <= hit_next;
      if (clr)            round_hit <= 1'b0;
      else if (lose_life) round_hit <= 1'b1;
    end
  end

endmodule

// File: rtl/wall_round_controller.sv
// Round progression controller: countdown, wall advance with per-round speed-up, lives and score.
//   state        | meaning
//   GS_IDLE      | after reset, waiting for start
//   GS_COUNTDOWN | pre-round hold of COUNTDOWN_FRAMES frames
//   GS_PLAYING   | wall advancing, collision judge armed
//   GS_WON       | all rounds cleared, waiting for start
//   GS_LOST      | out of lives, waiting for start
module wall_round_controller
  import wall_game_pkg::*;
#(
  parameter int SCREEN_WIDTH             = 1280,
  parameter int SCREEN_HEIGHT            = 720,
  parameter int GOAL_DEPTH               = 60,
  parameter int GOAL_DEPTH_DELTA         = 10,
  parameter int MAX_WALL_DEPTH           = 75,
  parameter int MAX_FRAMES_PER_WALL_TICK = 15,
  parameter int MIN_FRAMES_PER_WALL_TICK = 3,
  parameter int SPEEDUP_STEP             = 2,
  parameter int MAX_ROUNDS               = 5,
  parameter int NUM_WALLS                = 10,
  parameter int NUM_LIVES                = 3,
  parameter int COLLISION_THRESHOLD      = 64,
  parameter int COUNTDOWN_FRAMES         = 60,
  parameter int SCORE_CLEAN              = 10
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_game_in,
  wall_round_controller_if.slave       pix,
  output logic [DEPTH_W-1:0]           wall_depth_out,
  output logic [$clog2(NUM_WALLS)-1:0] wall_idx_out,
  output logic [7:0]                   round_out,
  output logic [3:0]                   lives_out,
  output logic [15:0]                  score_out,
  output logic [2:0]                   game_state,
  output logic                         life_lost_pulse_out,
  output logic                         round_pass_pulse_out
);

  localparam int IDX_W  = $clog2(NUM_WALLS);
  localparam int TICK_W = $clog2(MAX_FRAMES_PER_WALL_TICK + 1);
  localparam int CD_W   = $clog2(COUNTDOWN_FRAMES + 1);
  localparam logic [DEPTH_W-1:0] WIN_LO     = DEPTH_W'(depth_win_lo(GOAL_DEPTH, GOAL_DEPTH_DELTA));
  localparam logic [DEPTH_W-1:0] WIN_HI     = DEPTH_W'(depth_win_hi(GOAL_DEPTH, GOAL_DEPTH_DELTA));
  localparam logic [DEPTH_W-1:0] LAST_DEPTH = DEPTH_W'(MAX_WALL_DEPTH - 1);
  localparam logic [15:0]        SCORE_INC  = 16'(SCORE_CLEAN);

  game_state_t       state;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] tick_reload;
  logic [TICK_W-1:0] period_m1;
  logic [CD_W-1:0]   cd_cnt;

  logic new_frame;
  logic pixel_hit;
  logic playing;
  logic in_window;
  logic lose_life;
  logic round_hit;
  logic out_of_lives;
  logic round_end;
  logic game_start;

  assign new_frame = pix.data_valid_in
                     && pix.hcount_in == 11'(SCREEN_WIDTH - 1)
                     && pix.vcount_in == 10'(SCREEN_HEIGHT - 1);
  assign pixel_hit    = pix.data_valid_in & pix.is_wall_in & pix.is_person_in;
  assign playing      = (state == GS_PLAYING);
  assign in_window    = (wall_depth_out >= WIN_LO) && (wall_depth_out <= WIN_HI);
  assign out_of_lives = lose_life && (lives_out == 4'd1);
  // A losing frame that empties the lives counter pre-empts the round end.
  assign round_end    = playing && new_frame && !out_of_lives
                        && (tick_cnt == '0) && (wall_depth_out == LAST_DEPTH);
  assign game_start   = start_game_in && (state inside {GS_IDLE, GS_WON, GS_LOST});
  assign period_m1    = TICK_W'(tick_period(int'(round_out), MAX_FRAMES_PER_WALL_TICK,
                                            MIN_FRAMES_PER_WALL_TICK, SPEEDUP_STEP) - 1);
  assign game_state   = state;

  collision_judge #(
    .COLLISION_THRESHOLD(COLLISION_THRESHOLD)
  ) u_judge (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .clr       (game_start || round_end),
    .count_en  (playing && in_window),
    .pixel_hit (pixel_hit),
    .frame_end (playing && new_frame),
    .lose_life (lose_life),
    .round_hit (round_hit)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= GS_IDLE;
      wall_depth_out       <= '0;
      wall_idx_out         <= '0;
      round_out            <= '0;
      lives_out            <= 4'(NUM_LIVES);
      score_out            <= '0;
      tick_cnt             <= '0;
      tick_reload          <= '0;
      cd_cnt               <= '0;
      life_lost_pulse_out  <= 1'b0;
      round_pass_pulse_out <= 1'b0;
    end else begin
      life_lost_pulse_out  <= lose_life;
      round_pass_pulse_out <= round_end;
      case (state)
        GS_IDLE, GS_WON, GS_LOST: begin
          wall_depth_out <= '0;
          tick_cnt       <= '0;
          if (start_game_in) begin
            state        <= GS_COUNTDOWN;
            round_out    <= '0;
            lives_out    <= 4'(NUM_LIVES);
            score_out    <= '0;
            wall_idx_out <= '0;
            cd_cnt       <= CD_W'(COUNTDOWN_FRAMES - 1);
          end
        end
        GS_COUNTDOWN: begin
          if (new_frame) begin
            if (cd_cnt == '0) begin
              state          <= GS_PLAYING;
              wall_depth_out <= '0;
              tick_cnt       <= period_m1;
              tick_reload    <= period_m1;
            end else begin
              cd_cnt <= cd_cnt - CD_W'(1);
            end
          end
        end
        GS_PLAYING: begin
          if (new_frame) begin
            if (lose_life) lives_out <= lives_out - 4'd1;
            if (out_of_lives) begin
              state          <= GS_LOST;
              wall_depth_out <= '0;
              tick_cnt       <= '0;
            end else if (tick_cnt != '0) begin
              tick_cnt <= tick_cnt - TICK_W'(1);
            end else begin
              tick_cnt <= tick_reload;
              if (round_end) begin
                wall_depth_out <= '0;
                if (!round_hit && !lose_life) begin
                  if (score_out > 16'hFFFF - SCORE_INC) score_out <= 16'hFFFF;
                  else                                  score_out <= score_out + SCORE_INC;
                end
                round_out    <= round_out + 8'd1;
                wall_idx_out <= (wall_idx_out == IDX_W'(NUM_WALLS - 1)) ? '0
                                                                        : wall_idx_out + IDX_W'(1);
                cd_cnt       <= CD_W'(COUNTDOWN_FRAMES - 1);
                state        <= (round_out == 8'(MAX_ROUNDS - 1)) ? GS_WON : GS_COUNTDOWN;
              end else begin
                wall_depth_out <= wall_depth_out + 8'd1;
              end
            end
          end
        end
        default: state <= GS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pix.hcount_out       <= '0;
      pix.vcount_out       <= '0;
      pix.data_valid_out   <= 1'b0;
      pix.is_wall_out      <= 1'b0;
      pix.is_person_out    <= 1'b0;
      pix.player_depth_out <= '0;
      pix.is_collision_out <= 1'b0;
    end else begin
      pix.hcount_out       <= pix.hcount_in;
      pix.vcount_out       <= pix.vcount_in;
      pix.data_valid_out   <= pix.data_valid_in;
      pix.is_wall_out      <= pix.is_wall_in;
      pix.is_person_out    <= pix.is_person_in;
      pix.player_depth_out <= pix.player_depth_in;
      pix.is_collision_out <= pixel_hit;
    end
  end

endmodule

// File: tb/tb_wall_round_controller.sv
// Randomized raster/game stimulus against a frame-level game model; per-cycle scoreboard.
module tb_wall_round_controller;

  localparam int W = 8, H = 4, CDF = 2, MAXF = 5, MINF = 1, STEP = 2;
  localparam int MAXD = 4, GOAL = 2, DELTA = 1, THR = 3, NL = 3, MR = 5, NW = 3, SC = 10;
  localparam int H_TOT = W + 3, V_TOT = H + 1;
  localparam int N_CYCLES = 45000;
  localparam int S_LOST = 0, S_PLAYING = 1, S_WON = 2, S_IDLE = 3, S_COUNTDOWN = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_game_in;
  logic [7:0]  wall_depth_out;
  logic [1:0]  wall_idx_out;
  logic [7:0]  round_out;
  logic [3:0]  lives_out;
  logic [15:0] score_out;
  logic [2:0]  game_state;
  logic        life_lost_pulse_out;
  logic        round_pass_pulse_out;

  wall_round_controller_if pix();

  always #5 clk_in = ~clk_in;

  wall_round_controller #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .GOAL_DEPTH(GOAL), .GOAL_DEPTH_DELTA(DELTA),
    .MAX_WALL_DEPTH(MAXD), .MAX_FRAMES_PER_WALL_TICK(MAXF), .MIN_FRAMES_PER_WALL_TICK(MINF),
    .SPEEDUP_STEP(STEP), .MAX_ROUNDS(MR), .NUM_WALLS(NW), .NUM_LIVES(NL),
    .COLLISION_THRESHOLD(THR), .COUNTDOWN_FRAMES(CDF), .SCORE_CLEAN(SC)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .start_game_in        (start_game_in),
    .pix                  (pix),
    .wall_depth_out       (wall_depth_out),
    .wall_idx_out         (wall_idx_out),
    .round_out            (round_out),
    .lives_out            (lives_out),
    .score_out            (score_out),
    .game_state           (game_state),
    .life_lost_pulse_out  (life_lost_pulse_out),
    .round_pass_pulse_out (round_pass_pulse_out)
  );

  typedef struct {
    int h, v, dv, wall, person, coll, pd;
    int depth, idx, round_n, lives, score, gs, lp, rp;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, errors = 0;
  int pass_seen = 0;

  // Game model state: plain counters counting up, frames measured since last event.
  int m_state, m_depth, m_round, m_lives, m_score, m_idx;
  int m_hits, m_hit_round, m_frames, m_tick, m_period;
  int n_pass = 0, n_won = 0, n_lost = 0, n_life = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit start, input int h, input int v,
                            input bit dv, input bit wall, input bit person, input int pd,
                            output exp_t e);
    bit nf, hit, lose;
    int p;
    nf  = dv && h == W - 1 && v == H - 1;
    hit = dv && wall && person;
    e.lp = 0;
    e.rp = 0;
    if (rst) begin
      m_state = S_IDLE; m_depth = 0; m_round = 0; m_lives = NL; m_score = 0; m_idx = 0;
      m_hits = 0; m_hit_round = 0; m_frames = 0; m_tick = 0; m_period = 0;
    end else begin
      case (m_state)
        S_IDLE, S_WON, S_LOST: begin
          if (start) begin
            m_state = S_COUNTDOWN; m_round = 0; m_lives = NL; m_score = 0; m_idx = 0;
            m_frames = 0; m_hits = 0; m_hit_round = 0;
          end
        end
        S_COUNTDOWN: begin
          if (nf) begin
            m_frames++;
            if (m_frames == CDF) begin
              p = MAXF - m_round * STEP;
              m_period = (p < MINF) ? MINF : p;
              m_state = S_PLAYING; m_depth = 0; m_tick = 0;
            end
          end
        end
        default: begin
          if (hit && m_depth >= GOAL - DELTA && m_depth <= GOAL + DELTA && m_hits < THR) m_hits++;
          if (nf) begin
            lose = (m_hits >= THR) && (m_hit_round == 0);
            m_hits = 0;
            if (lose) begin
              m_lives--; m_hit_round = 1; e.lp = 1; n_life++;
            end
            if (lose && m_lives == 0) begin
              m_state = S_LOST; m_depth = 0; n_lost++;
            end else begin
              m_tick++;
              if (m_tick == m_period) begin
                m_tick = 0;
                if (m_depth + 1 == MAXD) begin
                  e.rp = 1; n_pass++;
                  if (m_hit_round == 0) m_score = (m_score + SC > 65535) ? 65535 : m_score + SC;
                  m_round++; m_idx = (m_idx + 1) % NW; m_hit_round = 0; m_depth = 0; m_frames = 0;
                  if (m_round == MR) begin
                    m_state = S_WON; n_won++;
                  end else begin
                    m_state = S_COUNTDOWN;
                  end
                end else begin
                  m_depth++;
                end
              end
            end
          end
        end
      endcase
    end
    e.h      = rst ? 0 : h;
    e.v      = rst ? 0 : v;
    e.dv     = rst ? 0 : int'(dv);
    e.wall   = rst ? 0 : int'(wall);
    e.person = rst ? 0 : int'(person);
    e.coll   = rst ? 0 : int'(hit);
    e.pd     = rst ? 0 : pd;
    e.depth  = m_depth;
    e.idx    = m_idx;
    e.round_n = m_round;
    e.lives  = m_lives;
    e.score  = m_score;
    e.gs     = m_state;
  endtask

  // Stimulus: free-running raster with blanking, random pixel dropouts and per-frame hit density.
  initial begin
    exp_t e;
    int h, v, mode, r, pd;
    bit mid_rst_done, rst_now, dv, wall, person;
    h = 0; v = 0; mode = 0; mid_rst_done = 0;
    rst_in = 1'b1; start_game_in = 1'b0;
    pix.hcount_in = '0; pix.vcount_in = '0; pix.data_valid_in = 1'b0;
    pix.is_wall_in = 1'b0; pix.is_person_in = 1'b0; pix.player_depth_in = '0;
    @(posedge clk_in); #1;
    for (int cyc = 0; cyc < N_CYCLES && errors < 50; cyc++) begin
      if (h == 0 && v == 0) begin
        r = $urandom_range(0, 9);
        mode = (r < 8) ? 0 : ((r == 8) ? 1 : 2);
      end
      rst_now = (cyc < 3) || ($urandom_range(0, 29999) == 0);
      if (!mid_rst_done && m_state == S_PLAYING && m_depth == 2 && $urandom_range(0, 3) == 0) begin
        rst_now = 1'b1;
        mid_rst_done = 1'b1;
      end
      dv   = (h < W) && (v < H) && ($urandom_range(0, 19) != 0);
      wall = 1'($urandom_range(0, 1));
      case (mode)
        0:       person = 1'b0;
        1:       person = ($urandom_range(0, 7) == 0);
        default: person = 1'($urandom_range(0, 1));
      endcase
      pd = $urandom_range(0, 255);
      rst_in               = rst_now;
      start_game_in        = ($urandom_range(0, 199) == 0);
      pix.hcount_in        = 11'(h);
      pix.vcount_in        = 10'(v);
      pix.data_valid_in    = dv;
      pix.is_wall_in       = wall;
      pix.is_person_in     = person;
      pix.player_depth_in  = 8'(pd);
      model_step(rst_now, start_game_in, h, v, dv, wall, person, pd, e);
      sb_q.push_back(e);
      @(posedge clk_in); #1;
      h++;
      if (h == H_TOT) begin
        h = 0;
        v++;
        if (v == V_TOT) v = 0;
      end
    end
    @(negedge clk_in); #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    check("round_pass_count", 32'(pass_seen), 32'(n_pass));
    $display("games won=%0d lost=%0d rounds passed=%0d lives lost=%0d", n_won, n_lost, n_pass, n_life);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Monitor: each cycle the DUT presents a registered snapshot; pop its expected twin.
  initial begin
    exp_t e;
    @(posedge clk_in); #1;
    forever begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: actual=empty required=entry at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        if (round_pass_pulse_out === 1'b1) pass_seen++;
        check("hcount_out",       32'(pix.hcount_out),       e.h);
        check("vcount_out",       32'(pix.vcount_out),       e.v);
        check("data_valid_out",   32'(pix.data_valid_out),   e.dv);
        check("is_wall_out",      32'(pix.is_wall_out),      e.wall);
        check("is_person_out",    32'(pix.is_person_out),    e.person);
        check("is_collision_out", 32'(pix.is_collision_out), e.coll);
        check("player_depth_out", 32'(pix.player_depth_out), e.pd);
        check("game_state",       32'(game_state),           e.gs);
        check("wall_depth_out",   32'(wall_depth_out),       e.depth);
        check("wall_idx_out",     32'(wall_idx_out),         e.idx);
        check("round_out",        32'(round_out),            e.round_n);
        check("lives_out",        32'(lives_out),            e.lives);
        check("score_out",        32'(score_out),            e.score);
        check("life_lost_pulse",  32'(life_lost_pulse_out),  e.lp);
        check("round_pass_pulse", 32'(round_pass_pulse_out), e.rp);
      end
    end
  end

endmodule
